mar_ctrl_sequencer: RTL and testbench

//  Microsequencer for the model computer: a 6-phase ring (T1..T6) that drives the load/enable

---
 rtl/mar_ctrl_sequencer_pkg.sv | 40 ++++
 rtl/mar_ctrl_decode.sv | 54 +++++
 rtl/mar_ctrl_sequencer.sv | 78 +++++++
 tb/tb_mar_ctrl_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mar_ctrl_sequencer_pkg.sv
// Shared definitions for the model-computer microsequencer: opcodes, ring states
// and the packed strobe vector handed from the decoder to the top.
package mar_ctrl_sequencer_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    // Encoding doubles as the debug phase output.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    typedef struct packed {
        logic epc;
        logic cpc;
        logic imar;
        logic eram;
        logic iir;
        logic eir;
        logic ia;
        logic ea;
        logic ib;
        logic sub;
        logic eu;
        logic iout;
    } strobe_t;

endpackage

// File: rtl/mar_ctrl_decode.sv
// Combinational strobe decode from ring state and IR opcode nibble.
// Opcode only matters in T4..T6; fetch phases are identical for every instruction.
module mar_ctrl_decode
    import mar_ctrl_sequencer_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    output strobe_t         strb
);

    always_comb begin
        strb = '0;
        case (state)
            ST_T1: begin
                strb.epc  = 1'b1;
                strb.imar = 1'b1;
            end
            ST_T2: strb.cpc = 1'b1;
            ST_T3: begin
                strb.eram = 1'b1;
                strb.iir  = 1'b1;
            end
            ST_T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    strb.eir  = 1'b1;
                    strb.imar = 1'b1;
                end else if (opcode == OP_OUT) begin
                    strb.ea   = 1'b1;
                    strb.iout = 1'b1;
                end
            end
            ST_T5: begin
                if (opcode == OP_LDA) begin
                    strb.eram = 1'b1;
                    strb.ia   = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    // Subtract select is set up a phase early so the ALU settles before T6.
                    strb.eram = 1'b1;
                    strb.ib   = 1'b1;
                    strb.sub  = (opcode == OP_SUB);
                end
            end
            ST_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    strb.eu  = 1'b1;
                    strb.ia  = 1'b1;
                    strb.sub = (opcode == OP_SUB);
                end
            end
            default: strb = '0;
        endcase
    end

endmodule

// File: rtl/mar_ctrl_sequencer.sv
// Six-phase ring microsequencer: owns the state register and next-state logic,
// strobes are decoded from the current state by mar_ctrl_decode.
//
//  state | meaning
//  IDLE  | waiting for run, all strobes low
//  T1    | PC onto bus, MAR loads
//  T2    | PC increment
//  T3    | RAM onto bus, IR loads
//  T4    | execute 1 (operand address or OUT transfer; HLT exits here)
//  T5    | execute 2 (RAM operand into A or B)
//  T6    | execute 3 (ALU result into A); samples run
//  HALT  | stopped until reset
module mar_ctrl_sequencer
    import mar_ctrl_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OP_W-1:0] opcode,
    output logic            epc,
    output logic            cpc,
    output logic            imar,
    output logic            eram,
    output logic            iir,
    output logic            eir,
    output logic            ia,
    output logic            ea,
    output logic            ib,
    output logic            sub,
    output logic            eu,
    output logic            iout,
    output logic            halted,
    output logic [2:0]      phase
);

    state_t  state;
    strobe_t strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state <= run ? ST_T1 : ST_IDLE;
                ST_T1:   state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3:   state <= ST_T4;
                ST_T4:   state <= (opcode == OP_HLT) ? ST_HALT : ST_T5;
                ST_T5:   state <= ST_T6;
                ST_T6:   state <= run ? ST_T1 : ST_IDLE;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    mar_ctrl_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .strb   (strb)
    );

    assign epc    = strb.epc;
    assign cpc    = strb.cpc;
    assign imar   = strb.imar;
    assign eram   = strb.eram;
    assign iir    = strb.iir;
    assign eir    = strb.eir;
    assign ia     = strb.ia;
    assign ea     = strb.ea;
    assign ib     = strb.ib;
    assign sub    = strb.sub;
    assign eu     = strb.eu;
    assign iout   = strb.iout;
    assign halted = (state == ST_HALT);
    assign phase  = state;

endmodule

// File: tb/tb_mar_ctrl_sequencer.sv
// Scoreboard bench for mar_ctrl_sequencer: expected {halted, phase, strobes} words
// are queued as stimulus is driven and compared on the following falling edge.
module tb_mar_ctrl_sequencer;

    localparam logic [11:0] S_EPC  = 12'h800;
    localparam logic [11:0] S_CPC  = 12'h400;
    localparam logic [11:0] S_IMAR = 12'h200;
    localparam logic [11:0] S_ERAM = 12'h100;
    localparam logic [11:0] S_IIR  = 12'h080;
    localparam logic [11:0] S_EIR  = 12'h040;
    localparam logic [11:0] S_IA   = 12'h020;
    localparam logic [11:0] S_EA   = 12'h010;
    localparam logic [11:0] S_IB   = 12'h008;
    localparam logic [11:0] S_SUB  = 12'h004;
    localparam logic [11:0] S_EU   = 12'h002;
    localparam logic [11:0] S_IOUT = 12'h001;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       epc, cpc, imar, eram, iir, eir, ia, ea, ib, sub, eu, iout;
    logic       halted;
    logic [2:0] phase;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs;
    logic [15:0] expv;

    mar_ctrl_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .opcode (opcode),
        .epc    (epc),
        .cpc    (cpc),
        .imar   (imar),
        .eram   (eram),
        .iir    (iir),
        .eir    (eir),
        .ia     (ia),
        .ea     (ea),
        .ib     (ib),
        .sub    (sub),
        .eu     (eu),
        .iout   (iout),
        .halted (halted),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int ph, input logic [11:0] s);
        logic [2:0] p;
        p = ph[2:0];
        exp_q.push_back({(ph == 7), p, s});
    endtask

    task automatic sample();
        @(negedge clk);
        obs = {halted, phase, epc, cpc, imar, eram, iir, eir, ia, ea, ib, sub, eu, iout};
    endtask

    // Independent reference for the random section.
    function automatic logic [11:0] model_strb(input int ph, input logic [3:0] op);
        logic [11:0] s;
        s = '0;
        case (ph)
            1: s = S_EPC | S_IMAR;
            2: s = S_CPC;
            3: s = S_ERAM | S_IIR;
            4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) s = S_EIR | S_IMAR;
               else if (op == 4'hE) s = S_EA | S_IOUT;
            5: if (op == 4'h0) s = S_ERAM | S_IA;
               else if (op == 4'h1) s = S_ERAM | S_IB;
               else if (op == 4'h2) s = S_ERAM | S_IB | S_SUB;
            6: if (op == 4'h1) s = S_EU | S_IA;
               else if (op == 4'h2) s = S_EU | S_IA | S_SUB;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic int model_next(input int ph, input logic r, input logic [3:0] op);
        case (ph)
            0: return r ? 1 : 0;
            4: return (op == 4'hF) ? 7 : 5;
            6: return r ? 1 : 0;
            7: return 7;
            default: return ph + 1;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; opcode = 4'h0;
        repeat (2) @(posedge clk);
        push_exp(0, 12'h000);
        sample();
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset act %h exp %h", obs, expv);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) push_exp(0, 12'h000);
        for (int i = 0; i < 10; i++) begin
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL idle_hold cyc %0d act %h exp %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_lda();
        run = 1'b1; opcode = 4'b0000;
        push_exp(1, S_EPC | S_IMAR);
        push_exp(2, S_CPC);
        push_exp(3, S_ERAM | S_IIR);
        push_exp(4, S_EIR | S_IMAR);
        push_exp(5, S_ERAM | S_IA);
        push_exp(6, 12'h000);
        push_exp(1, S_EPC | S_IMAR);
        for (int i = 0; i < 7; i++) begin
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL lda cyc %0d act %h exp %h", i, obs, expv);
            end
        end
    endtask

    // Starts in T1; queues T2..T6 then the next T1.
    task automatic test_add_sub();
        for (int k = 0; k < 2; k++) begin
            logic [11:0] sb;
            opcode = (k == 0) ? 4'b0010 : 4'b0001;
            sb = (k == 0) ? S_SUB : 12'h000;
            push_exp(2, S_CPC);
            push_exp(3, S_ERAM | S_IIR);
            push_exp(4, S_EIR | S_IMAR);
            push_exp(5, S_ERAM | S_IB | sb);
            push_exp(6, S_EU | S_IA | sb);
            push_exp(1, S_EPC | S_IMAR);
            for (int i = 0; i < 6; i++) begin
                sample();
                expv = exp_q.pop_front();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL %s cyc %0d act %h exp %h", (k == 0) ? "sub" : "add", i, obs, expv);
                end
            end
        end
    endtask

    task automatic test_out_hlt();
        opcode = 4'b1110;
        push_exp(2, S_CPC);
        push_exp(3, S_ERAM | S_IIR);
        push_exp(4, S_EA | S_IOUT);
        push_exp(5, 12'h000);
        push_exp(6, 12'h000);
        push_exp(1, S_EPC | S_IMAR);
        for (int i = 0; i < 6; i++) begin
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL out cyc %0d act %h exp %h", i, obs, expv);
            end
        end
        opcode = 4'b1111;
        push_exp(2, S_CPC);
        push_exp(3, S_ERAM | S_IIR);
        push_exp(4, 12'h000);
        push_exp(7, 12'h000);
        for (int i = 0; i < 4; i++) begin
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL hlt cyc %0d act %h exp %h", i, obs, expv);
            end
        end
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            opcode = 4'(i);
            push_exp(7, 12'h000);
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL halt_hold cyc %0d act %h exp %h", i, obs, expv);
            end
        end
        rst = 1'b1;
        push_exp(0, 12'h000);
        sample();
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL halt_reset act %h exp %h", obs, expv);
        end
        rst = 1'b0; run = 1'b0;
    endtask

    task automatic test_reset_mid();
        run = 1'b1; opcode = 4'b0001;
        push_exp(1, S_EPC | S_IMAR);
        push_exp(2, S_CPC);
        push_exp(3, S_ERAM | S_IIR);
        push_exp(4, S_EIR | S_IMAR);
        push_exp(5, S_ERAM | S_IB);
        for (int i = 0; i < 5; i++) begin
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL pre_reset cyc %0d act %h exp %h", i, obs, expv);
            end
        end
        rst = 1'b1;
        push_exp(0, 12'h000);
        sample();
        rst = 1'b0; run = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(0, 12'h000);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL mid_reset cyc %0d act %h exp %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_run_drop_random();
        int mph;
        int nxt;
        run = 1'b1; opcode = 4'b0001;
        push_exp(1, S_EPC | S_IMAR);
        push_exp(2, S_CPC);
        push_exp(3, S_ERAM | S_IIR);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                run = 1'b0;
                push_exp(4, S_EIR | S_IMAR);
                push_exp(5, S_ERAM | S_IB);
                push_exp(6, S_EU | S_IA);
                push_exp(0, 12'h000);
                push_exp(0, 12'h000);
            end
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL run_drop cyc %0d act %h exp %h", i, obs, expv);
            end
        end
        mph = 0;
        for (int i = 0; i < 200; i++) begin
            run = ($urandom_range(0, 7) != 0);
            if (mph == 0 || mph == 1 || mph == 2 || mph == 6) begin
                opcode = 4'($urandom_range(0, 15));
                if (opcode == 4'hF) opcode = 4'h7;
            end
            nxt = model_next(mph, run, opcode);
            push_exp(nxt, model_strb(nxt, opcode));
            sample();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc %0d op %h act %h exp %h", i, opcode, obs, expv);
            end
            checks++;
            if ($countones({epc, eram, eir, ea, eu}) > 1) begin
                errors++;
                $display("FAIL bus_onehot cyc %0d act %b exp at most one", i, {epc, eram, eir, ea, eu});
            end
            mph = nxt;
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_out_hlt();
        test_reset_mid();
        test_run_drop_random();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover act %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
